// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/acknowledge bus of the load/store unit.
// master = CPU datapath/control, slave = mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        misalign;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ack, busy, misalign
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ack, busy, misalign
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit: byte/half/word accesses onto a word-only RAM, RMW for partial stores.
// Optional feature macro ACC_CNT_EN adds ld_cnt/st_cnt access counters.
module mem_access_ctrl #(
    parameter int RD_LAT = 1
`ifdef ACC_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_ctrl_if.slave    cpu,
    output logic                Mem_Write,
    output logic [7:0]          DM_Addr,
    output logic [31:0]         M_W_Data,
    input  logic [31:0]         M_R_Data
`ifdef ACC_CNT_EN
    ,
    output logic [CNT_W-1:0]    ld_cnt,
    output logic [CNT_W-1:0]    st_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    // Rejects odd half addresses, unaligned words and the reserved size code.
    function automatic logic misaligned_f(input logic [1:0] size, input logic [1:0] lane);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lane[0];
            2'b10:   m = (lane != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_f(input logic [31:0] word, input logic [1:0] size,
                                           input logic sext, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            2'b00:   r = {{24{sext & b[7]}}, b};
            2'b01:   r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Bytes outside the selected lane are passed through unchanged from the read word.
    function automatic logic [31:0] merge_f(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = old;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0]  = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  rd_cnt_r, rd_cnt_s;
    logic        we_r, sext_r;
    logic [1:0]  size_r;
    logic [7:0]  addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r, rdata_s;
    logic        ack_r, busy_r, misalign_r;
    logic        accept_s, mis_s, rd_done_s;
    logic        mem_write_s;
    logic [7:0]  dm_addr_s;
    logic [31:0] m_w_data_s;

    assign accept_s  = (state_r == IDLE) && cpu.req;
    assign mis_s     = misaligned_f(cpu.size, cpu.addr[1:0]);
    assign rd_done_s = (state_r == RD) && (rd_cnt_r == RD_LAT_C);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu.req) begin
                    if (mis_s) begin
                        state_s = ERR;
                    end else if (cpu.we && (cpu.size == 2'b10)) begin
                        state_s = WR;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (rd_done_s) begin
                    if (we_r) begin
                        state_s = WR;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = RD;
                end
            end
            WR:      state_s = DONE;
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with the state being entered.
    always_comb begin
        rd_cnt_s    = 2'd0;
        rdata_s     = rdata_r;
        dm_addr_s   = DM_Addr;
        m_w_data_s  = M_W_Data;
        mem_write_s = (state_s == WR);
        if (state_r == RD) begin
            rd_cnt_s = rd_cnt_r + 2'd1;
        end else begin
            rd_cnt_s = 2'd0;
        end
        if (accept_s && !mis_s) begin
            dm_addr_s = {cpu.addr[7:2], 2'b00};
        end else begin
            dm_addr_s = DM_Addr;
        end
        if (accept_s && cpu.we && (cpu.size == 2'b10) && !mis_s) begin
            m_w_data_s = cpu.wdata;
        end else if (rd_done_s && we_r) begin
            m_w_data_s = merge_f(M_R_Data, wdata_r, size_r, addr_r[1:0]);
        end else begin
            m_w_data_s = M_W_Data;
        end
        if (rd_done_s && !we_r) begin
            rdata_s = load_f(M_R_Data, size_r, sext_r, addr_r[1:0]);
        end else begin
            rdata_s = rdata_r;
        end
    end

    // State register and read-latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            rd_cnt_r <= 2'd0;
        end else begin
            state_r  <= state_s;
            rd_cnt_r <= rd_cnt_s;
        end
    end

    // Request capture; only an accepted request updates the latched fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            sext_r  <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= 8'h00;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= cpu.we;
            sext_r  <= cpu.sign_ext;
            size_r  <= cpu.size;
            addr_r  <= cpu.addr;
            wdata_r <= cpu.wdata;
        end
    end

    // Registered CPU-side and RAM-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r    <= 32'h0000_0000;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            misalign_r <= 1'b0;
            Mem_Write  <= 1'b0;
            DM_Addr    <= 8'h00;
            M_W_Data   <= 32'h0000_0000;
        end else begin
            rdata_r    <= rdata_s;
            ack_r      <= (state_s == DONE) || (state_s == ERR);
            busy_r     <= (state_s != IDLE);
            misalign_r <= (state_s == ERR);
            Mem_Write  <= mem_write_s;
            DM_Addr    <= dm_addr_s;
            M_W_Data   <= m_w_data_s;
        end
    end

    assign cpu.rdata    = rdata_r;
    assign cpu.ack      = ack_r;
    assign cpu.busy     = busy_r;
    assign cpu.misalign = misalign_r;

`ifdef ACC_CNT_EN
    // Completed-access counters; bumped as DONE is entered, so they move with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (state_s == DONE) begin
            if (we_r) begin
                st_cnt <= st_cnt + 1'b1;
            end else begin
                ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
